paddle_position_ctrl: RTL and testbench

Upstream stage of the paddle bitmap. It holds the paddle's horizontal position and updates it once per video frame from the left/right keys, with acceleration and wall clamping. For every scanned pixel it produces the registered InsideRectangle flag and the 11-bit offsetX/offsetY into the paddle's 64x16 bitmap. These outputs drive the paddle bitmap stage directly.

---
 rtl/paddle_position_ctrl.sv | 167 ++++++++++++++++
 tb/tb_paddle_position_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_position_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : paddle_position_ctrl
//  Purpose  : Holds the paddle's horizontal position, updates it once per
//             frame from the left/right keys (with acceleration and wall
//             clamping), and produces the registered per-pixel hit flag and
//             bitmap offsets for the paddle bitmap stage.
//  Ports    :
//    clk             in   1   pixel clock
//    resetN          in   1   asynchronous active-low reset
//    startOfFrame    in   1   one-cycle pulse at start of each frame
//    leftKey         in   1   move-left request (level)
//    rightKey        in   1   move-right request (level)
//    freeze          in   1   game paused, position held (level)
//    pixelX          in   11  current scan X
//    pixelY          in   11  current scan Y
//    InsideRectangle out  1   registered: pixel inside paddle box
//    offsetX         out  11  registered: pixelX - topLeftX when inside
//    offsetY         out  11  registered: pixelY - PADDLE_Y when inside
//    topLeftX        out  11  current paddle left edge
//  Revision : 1.0  initial release
// ============================================================================
module paddle_position_ctrl #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int PADDLE_WIDTH  = 64,
    parameter int PADDLE_HEIGHT = 16,
    parameter int PADDLE_Y      = 440,
    parameter int INIT_X        = 288,
    parameter int START_SPEED   = 2,
    parameter int ACCEL         = 1,
    parameter int MAX_SPEED     = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        freeze,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [10:0] topLeftX
);

    // Wide enough to hold speed+ACCEL before saturation.
    localparam int SPEED_W = $clog2(MAX_SPEED + ACCEL + 1);

    localparam logic signed [11:0]  c_max_x       = 12'(SCREEN_WIDTH - PADDLE_WIDTH);
    localparam logic [10:0]         c_init_x      = 11'(INIT_X);
    localparam logic [SPEED_W-1:0]  c_start_speed = SPEED_W'(START_SPEED);
    localparam logic [SPEED_W:0]    c_accel_ext   = (SPEED_W+1)'(ACCEL);
    localparam logic [SPEED_W:0]    c_max_spd_ext = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [10:0]         c_paddle_y    = 11'(PADDLE_Y);
    localparam logic [11:0]         c_y_end       = 12'(PADDLE_Y + PADDLE_HEIGHT);
    localparam logic [11:0]         c_width_ext   = 12'(PADDLE_WIDTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MOVE_LEFT  = 2'd1,
        MOVE_RIGHT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [10:0]          top_left_x_q, top_left_x_d;
    logic                 inside_q, inside_d;
    logic [10:0]          offset_x_q, offset_x_d;
    logic [10:0]          offset_y_q, offset_y_d;

    logic [SPEED_W:0]     w_speed_sum;
    logic [SPEED_W-1:0]   w_speed_acc;
    logic signed [11:0]   w_next_x;
    logic [11:0]          w_x_end;

    // Saturating acceleration used while the same direction stays held.
    assign w_speed_sum = {1'b0, speed_q} + c_accel_ext;
    assign w_speed_acc = (w_speed_sum > c_max_spd_ext) ? c_max_spd_ext[SPEED_W-1:0]
                                                        : w_speed_sum[SPEED_W-1:0];

    // ------------------------------------------------------------------
    // Movement FSM: only evaluates on an unfrozen start-of-frame pulse.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        speed_d      = speed_q;
        top_left_x_d = top_left_x_q;
        w_next_x     = '0;

        if (startOfFrame && !freeze) begin
            if (leftKey == rightKey) begin
                state_d = IDLE;
                speed_d = '0;
            end else begin
                if (leftKey) begin
                    speed_d = (state_q == MOVE_LEFT) ? w_speed_acc : c_start_speed;
                    state_d = MOVE_LEFT;
                end else begin
                    speed_d = (state_q == MOVE_RIGHT) ? w_speed_acc : c_start_speed;
                    state_d = MOVE_RIGHT;
                end

                // Signed 12-bit so a step past the left wall shows up as negative.
                if (leftKey) begin
                    w_next_x = $signed({1'b0, top_left_x_q}) - $signed(12'(speed_d));
                end else begin
                    w_next_x = $signed({1'b0, top_left_x_q}) + $signed(12'(speed_d));
                end

                if (w_next_x < 0) begin
                    top_left_x_d = '0;
                    speed_d      = '0;
                    state_d      = IDLE;
                end else if (w_next_x > c_max_x) begin
                    top_left_x_d = c_max_x[10:0];
                    speed_d      = '0;
                    state_d      = IDLE;
                end else begin
                    top_left_x_d = w_next_x[10:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel path: compares against the current (pre-update) position.
    // ------------------------------------------------------------------
    always_comb begin
        w_x_end    = {1'b0, top_left_x_q} + c_width_ext;
        inside_d   = (pixelX >= top_left_x_q) &&
                     ({1'b0, pixelX} < w_x_end) &&
                     (pixelY >= c_paddle_y) &&
                     ({1'b0, pixelY} < c_y_end);
        offset_x_d = '0;
        offset_y_d = '0;
        if (inside_d) begin
            offset_x_d = pixelX - top_left_x_q;
            offset_y_d = pixelY - c_paddle_y;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            speed_q      <= '0;
            top_left_x_q <= c_init_x;
            inside_q     <= 1'b0;
            offset_x_q   <= '0;
            offset_y_q   <= '0;
        end else begin
            state_q      <= state_d;
            speed_q      <= speed_d;
            top_left_x_q <= top_left_x_d;
            inside_q     <= inside_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
        end
    end

    assign InsideRectangle = inside_q;
    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign topLeftX        = top_left_x_q;

endmodule
`default_nettype wire

// File: tb/tb_paddle_position_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_paddle_position_ctrl
//  Purpose  : Directed self-checking bench for paddle_position_ctrl. Expected
//             values are queued when stimulus is applied and compared when the
//             DUT's registered outputs settle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_paddle_position_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        leftKey = 1'b0;
    logic        rightKey = 1'b0;
    logic        freeze = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [10:0] topLeftX;

    int errors = 0;
    int checks = 0;

    // Reference model of the movement behaviour.
    int m_x   = 288;
    int m_spd = 0;
    int m_st  = 0;   // 0 idle, 1 left, 2 right

    logic [10:0] exp_x_q[$];
    logic [22:0] exp_pix_q[$];

    paddle_position_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .leftKey         (leftKey),
        .rightKey        (rightKey),
        .freeze          (freeze),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .InsideRectangle (InsideRectangle),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .topLeftX        (topLeftX)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_x   = 288;
        m_spd = 0;
        m_st  = 0;
    endfunction

    function automatic void model_frame(input logic l, input logic r, input logic f);
        int nx;
        if (f) return;
        if (l == r) begin
            m_st  = 0;
            m_spd = 0;
            return;
        end
        if (l) begin
            m_spd = (m_st == 1) ? ((m_spd + 1 > 8) ? 8 : m_spd + 1) : 2;
            m_st  = 1;
            nx    = m_x - m_spd;
        end else begin
            m_spd = (m_st == 2) ? ((m_spd + 1 > 8) ? 8 : m_spd + 1) : 2;
            m_st  = 2;
            nx    = m_x + m_spd;
        end
        if (nx < 0) begin
            m_x = 0; m_spd = 0; m_st = 0;
        end else if (nx > 576) begin
            m_x = 576; m_spd = 0; m_st = 0;
        end else begin
            m_x = nx;
        end
    endfunction

    // One start-of-frame pulse with the given key/freeze levels.
    task automatic frame(input string tag, input logic l, input logic r, input logic f);
        @(negedge clk);
        leftKey = l; rightKey = r; freeze = f; startOfFrame = 1'b1;
        model_frame(l, r, f);
        exp_x_q.push_back(m_x[10:0]);
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        check(tag, 32'(topLeftX), 32'(exp_x_q.pop_front()));
    endtask

    // Drive one pixel and compare the registered outputs a cycle later.
    task automatic pix(input string tag, input int px, input int py,
                       input logic ein, input int eox, input int eoy);
        logic [22:0] e;
        @(negedge clk);
        pixelX = 11'(px); pixelY = 11'(py);
        exp_pix_q.push_back({ein, 11'(eox), 11'(eoy)});
        @(posedge clk); #1;
        e = exp_pix_q.pop_front();
        check({tag, "_in"}, 32'(InsideRectangle), 32'(e[22]));
        check({tag, "_ox"}, 32'(offsetX), 32'(e[21:11]));
        check({tag, "_oy"}, 32'(offsetY), 32'(e[10:0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        leftKey = 1'b0; rightKey = 1'b0; freeze = 1'b0; startOfFrame = 1'b0;
        pixelX = '0; pixelY = '0;
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_x",  32'(topLeftX),        32'd288);
        check("rst_in", 32'(InsideRectangle), 32'd0);
        check("rst_ox", 32'(offsetX),         32'd0);
        check("rst_oy", 32'(offsetY),         32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Right held from reset: speeds 2,3,4.
        frame("r1", 1'b0, 1'b1, 1'b0);
        check("r1_290", 32'(topLeftX), 32'd290);
        frame("r2", 1'b0, 1'b1, 1'b0);
        frame("r3", 1'b0, 1'b1, 1'b0);
        check("r3_297", 32'(topLeftX), 32'd297);

        // Leave a hit registered, then reset asynchronously mid-cycle.
        pix("pre_rst", 300, 445, 1'b1, 3, 5);
        @(posedge clk); #2;
        resetN = 1'b0;
        model_reset();
        #1;
        check("arst_x",  32'(topLeftX),        32'd288);
        check("arst_in", 32'(InsideRectangle), 32'd0);
        check("arst_ox", 32'(offsetX),         32'd0);
        check("arst_oy", 32'(offsetY),         32'd0);
        pixelX = '0; pixelY = '0; leftKey = 1'b0; rightKey = 1'b0;
        @(negedge clk);
        resetN = 1'b1;

        // Left held for 39 frames: saturation then left-wall clamp.
        for (int i = 1; i <= 39; i++) begin
            frame("left_run", 1'b1, 1'b0, 1'b0);
            if (i == 7)  check("left_f7_253", 32'(topLeftX), 32'd253);
            if (i == 38) check("left_f38_5",  32'(topLeftX), 32'd5);
        end
        check("left_clamp_0", 32'(topLeftX), 32'd0);
        frame("left_at_wall", 1'b1, 1'b0, 1'b0);
        check("left_stay_0", 32'(topLeftX), 32'd0);

        // Direction change and both-keys.
        do_reset();
        frame("dc_r1", 1'b0, 1'b1, 1'b0);
        frame("dc_r2", 1'b0, 1'b1, 1'b0);
        check("dc_293", 32'(topLeftX), 32'd293);
        frame("dc_l1", 1'b1, 1'b0, 1'b0);
        check("dc_291", 32'(topLeftX), 32'd291);
        frame("dc_both", 1'b1, 1'b1, 1'b0);
        check("dc_both_291", 32'(topLeftX), 32'd291);
        frame("dc_r_after_both", 1'b0, 1'b1, 1'b0);
        check("dc_restart_293", 32'(topLeftX), 32'd293);

        // Pixel path at topLeftX=288.
        do_reset();
        pix("p_mid",    300, 445, 1'b1, 12, 5);
        pix("p_corner", 351, 455, 1'b1, 63, 15);
        pix("p_xout",   352, 445, 1'b0, 0, 0);
        pix("p_yout",   300, 456, 1'b0, 0, 0);
        pix("p_xlow",   287, 445, 1'b0, 0, 0);
        pix("p_ylow",   300, 439, 1'b0, 0, 0);
        pix("p_origin", 288, 440, 1'b1, 0, 0);

        // Pixel evaluated on the update cycle uses the old position.
        @(negedge clk);
        pixelX = 11'd288; pixelY = 11'd440;
        rightKey = 1'b1; startOfFrame = 1'b1;
        model_frame(1'b0, 1'b1, 1'b0);
        exp_x_q.push_back(m_x[10:0]);
        exp_pix_q.push_back({1'b1, 11'd0, 11'd0});
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        begin
            logic [22:0] e;
            e = exp_pix_q.pop_front();
            check("sof_x",  32'(topLeftX), 32'(exp_x_q.pop_front()));
            check("sof_in", 32'(InsideRectangle), 32'(e[22]));
            check("sof_ox", 32'(offsetX), 32'(e[21:11]));
        end
        pix("post_sof_old", 289, 440, 1'b0, 0, 0);
        pix("post_sof_new", 353, 455, 1'b1, 63, 15);

        // Freeze holds position; release resumes.
        do_reset();
        for (int i = 0; i < 5; i++) frame("frz_hold", 1'b0, 1'b1, 1'b1);
        check("frz_288", 32'(topLeftX), 32'd288);
        frame("frz_rel1", 1'b0, 1'b1, 1'b0);
        check("frz_rel_290", 32'(topLeftX), 32'd290);
        frame("frz_rel2", 1'b0, 1'b1, 1'b0);
        check("frz_rel_293", 32'(topLeftX), 32'd293);
        frame("frz_mid1", 1'b0, 1'b1, 1'b1);
        frame("frz_mid2", 1'b0, 1'b1, 1'b1);
        check("frz_mid_293", 32'(topLeftX), 32'd293);
        frame("frz_resume", 1'b0, 1'b1, 1'b0);
        check("frz_resume_297", 32'(topLeftX), 32'd297);

        // Non-frame cycles with keys held must not move the paddle.
        @(negedge clk);
        rightKey = 1'b1; startOfFrame = 1'b0; freeze = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_sof_hold", 32'(topLeftX), 32'd297);

        // Right held until the right wall clamps.
        for (int i = 0; i < 45; i++) frame("right_run", 1'b0, 1'b1, 1'b0);
        check("right_clamp_576", 32'(topLeftX), 32'd576);
        pix("p_right_edge", 639, 455, 1'b1, 63, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
